// File: rtl/toggle_reg_bank.sv
// Bank of T flip-flops with HOLD/TOGGLE/COUNT/LOAD modes and a change flag.
// Optional registered parity output when TOGGLE_REG_PARITY_EN is defined.

module toggle_bit #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= RST_BIT;
        else     q <= q ^ t;
    end
endmodule

module toggle_reg_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] t_in,
    input  logic [WIDTH-1:0] load_val,
`ifdef TOGGLE_REG_PARITY_EN
    output logic             parity,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             chg
);
    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_COUNT  = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;

    // all1[i] / all0[i]: bits below i are all ones / all zeros, i.e. the
    // up/down toggle condition for bit i; the top entry covers the whole word.
    logic [WIDTH:0]   all1, all0;
    logic [WIDTH-1:0] t;

    assign all1[0] = 1'b1;
    assign all0[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign all1[i+1] = all1[i] & out[i];
            assign all0[i+1] = all0[i] & ~out[i];

            toggle_bit #(.RST_BIT(RST_VAL[i])) u_bit (
                .clk (clk),
                .rst (rst),
                .t   (t[i]),
                .q   (out[i])
            );
        end
    endgenerate

    always_comb begin
        t = '0;
        if (en) begin
            case (mode)
                MODE_HOLD:   t = '0;
                MODE_TOGGLE: t = t_in;
                MODE_COUNT:  t = dir ? all1[WIDTH-1:0] : all0[WIDTH-1:0];
                MODE_LOAD:   t = out ^ load_val;  // toggle only differing bits
                default:     t = '0;
            endcase
        end
    end

    assign tc = en && (mode == MODE_COUNT) && (dir ? all1[WIDTH] : all0[WIDTH]);

    // Any toggle request means the value changes on this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) chg <= 1'b0;
        else     chg <= |t;
    end

`ifdef TOGGLE_REG_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity <= ^RST_VAL;
        else     parity <= ^(out ^ t);
    end
`endif

endmodule

// File: tb/tb_toggle_reg_bank.sv
// Randomized bench for toggle_reg_bank with an arithmetic reference model,
// per-cycle compare process and directed literal checks.

module tb_toggle_reg_bank;
    localparam int        W    = 8;
    localparam logic [7:0] RV  = 8'h00;
    localparam logic [1:0] HOLD = 2'b00, TOG = 2'b01, CNT = 2'b10, LD = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = HOLD;
    logic         dir = 1'b0;
    logic [W-1:0] t_in = '0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] out;
    logic         tc, chg;
`ifdef TOGGLE_REG_PARITY_EN
    logic         parity;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    toggle_reg_bank #(.WIDTH(W), .RST_VAL(RV)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .t_in     (t_in),
        .load_val (load_val),
`ifdef TOGGLE_REG_PARITY_EN
        .parity   (parity),
`endif
        .out      (out),
        .tc       (tc),
        .chg      (chg)
    );

    always #5 clk = ~clk;

    // Reference model: the register value as plain integer arithmetic.
    int m_out = int'(RV);
    bit m_chg = 1'b0;

    always @(posedge clk or posedge rst) begin
        int nxt;
        if (rst) begin
            m_out <= int'(RV);
            m_chg <= 1'b0;
        end else begin
            nxt = m_out;
            if (en) begin
                case (mode)
                    TOG: nxt = m_out ^ int'(t_in);
                    CNT: nxt = dir ? (m_out + 1) % 256 : (m_out + 255) % 256;
                    LD:  nxt = int'(load_val);
                    default: nxt = m_out;
                endcase
            end
            m_chg <= (nxt != m_out);
            m_out <= nxt;
        end
    end

    function automatic bit m_tc();
        return en && mode == CNT && (dir ? m_out == 255 : m_out == 0);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("out", int'(out), m_out);
        chk("chg", int'(chg), int'(m_chg));
        chk("tc", int'(tc), int'(m_tc()));
`ifdef TOGGLE_REG_PARITY_EN
        chk("parity", int'(parity), int'(^m_out[7:0]));
`endif
    end

    // Inputs are presented just after an edge; returns just after the next edge.
    task automatic apply(input bit e, input logic [1:0] m, input bit d,
                         input logic [W-1:0] t, input logic [W-1:0] lv);
        en = e; mode = m; dir = d; t_in = t; load_val = lv;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state, and tc computed from RST_VAL while reset is held.
        #2;
        chk("rst_out", int'(out), 8'h00);
        chk("rst_chg", int'(chg), 0);
        chk("rst_tc_off", int'(tc), 0);
        en = 1'b1; mode = CNT; dir = 1'b0; #1;
        chk("rst_tc_down", int'(tc), 1);
        @(posedge clk); #1;
        chk("rst_hold", int'(out), 8'h00);
        rst = 1'b0;

        // Asynchronous reset mid-cycle from 5A.
        apply(1, LD, 0, 8'h00, 8'h5A);
        chk("ld_5a", int'(out), 8'h5A);
        chk("ld_5a_chg", int'(chg), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_out", int'(out), 8'h00);
        chk("async_chg", int'(chg), 0);
        rst = 1'b0;

        // TOGGLE.
        apply(1, LD, 0, 8'h00, 8'h0F);
        apply(1, TOG, 0, 8'hFF, 8'h00);
        chk("tog_f0", int'(out), 8'hF0);
        chk("tog_f0_chg", int'(chg), 1);
        apply(1, TOG, 0, 8'h00, 8'h00);
        chk("tog_hold", int'(out), 8'hF0);
        chk("tog_hold_chg", int'(chg), 0);

        // COUNT up through wrap.
        apply(1, LD, 0, 8'h00, 8'hFE);
        apply(1, CNT, 1, 8'h00, 8'h00);
        chk("up_ff", int'(out), 8'hFF);
        chk("up_ff_tc", int'(tc), 1);
        apply(1, CNT, 1, 8'h00, 8'h00);
        chk("up_00", int'(out), 8'h00);
        chk("up_00_tc", int'(tc), 0);
        apply(1, CNT, 1, 8'h00, 8'h00);
        chk("up_01", int'(out), 8'h01);

        // COUNT down through wrap.
        apply(1, LD, 0, 8'h00, 8'h01);
        apply(1, CNT, 0, 8'h00, 8'h00);
        chk("dn_00", int'(out), 8'h00);
        chk("dn_00_tc", int'(tc), 1);
        apply(1, CNT, 0, 8'h00, 8'h00);
        chk("dn_ff", int'(out), 8'hFF);
        chk("dn_ff_chg", int'(chg), 1);

        // LOAD of equal value, then disabled LOAD.
        apply(1, LD, 0, 8'h00, 8'hA5);
        apply(1, LD, 1, 8'hFF, 8'hA5);
        chk("ld_eq", int'(out), 8'hA5);
        chk("ld_eq_chg", int'(chg), 0);
        apply(0, LD, 0, 8'h00, 8'h3C);
        chk("en0_ld", int'(out), 8'hA5);
        chk("en0_chg", int'(chg), 0);

`ifdef TOGGLE_REG_PARITY_EN
        apply(1, LD, 0, 8'h00, 8'h07);
        chk("par_07", int'(parity), 1);
        apply(1, TOG, 0, 8'h01, 8'h00);
        chk("par_06_out", int'(out), 8'h06);
        chk("par_06", int'(parity), 0);
`endif

        // Randomized traffic with occasional mid-cycle resets.
        for (int k = 0; k < 3000; k++) begin
            logic [W-1:0] tv, lv;
            tv = ($urandom_range(0, 3) == 0) ? 8'h00 : W'($urandom);
            lv = ($urandom_range(0, 3) == 0) ? W'(m_out) : W'($urandom);
            rst = ($urandom_range(0, 40) == 0);
            apply($urandom_range(0, 7) != 0, 2'($urandom), 1'($urandom), tv, lv);
        end
        rst = 1'b0;
        apply(0, HOLD, 0, 8'h00, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/toggle_reg_bank.md
TOGGLE_REG_BANK -- requirements
Module: toggle_reg_bank

Interface
REQ-001 Parameter WIDTH, 8, number of toggle-register bits; legal range 1..32.
REQ-002 Parameter RST_VAL, {WIDTH{1'b0}}, value loaded into out on reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 en  input  1  operation enable; when 0, all state holds.
REQ-006 mode  input  2  operation select: 00 HOLD, 01 TOGGLE, 10 COUNT, 11 LOAD.
REQ-007 dir  input  1  COUNT direction: 1 up, 0 down; ignored in other modes.
REQ-008 t_in  input  WIDTH  per-bit toggle request used in TOGGLE mode.
REQ-009 load_val  input  WIDTH  value captured in LOAD mode.
REQ-010 out  output  WIDTH  registered toggle-bank state.
REQ-011 tc  output  1  terminal-count flag, combinational from registered state and inputs.
REQ-012 chg  output  1  registered flag: out changed value on the previous edge.

Function
REQ-013 Each bit SHALL be a T flip-flop: next = cur XOR t, with t per mode.
REQ-014 en=0: t=0 for all bits; out and chg SHALL hold, except chg SHALL clear to 0.
REQ-015 HOLD (00): out SHALL hold; chg SHALL be 0 on the next edge.
REQ-016 TOGGLE (01): out SHALL become out XOR t_in on the next edge; t_in=0 leaves out unchanged.
REQ-017 COUNT up (10, dir=1): bit i toggles iff bits 0..i-1 are all 1 (bit 0 always toggles); result SHALL equal out+1 mod 2^WIDTH.
REQ-018 COUNT down (10, dir=0): bit i toggles iff bits 0..i-1 are all 0 (bit 0 always toggles); result SHALL equal out-1 mod 2^WIDTH.
REQ-019 Wrap-around: up from all-ones SHALL give all-zeros; down from all-zeros SHALL give all-ones; no saturation.
REQ-020 LOAD (11): out SHALL take load_val on the next edge, regardless of dir and t_in.
REQ-021 tc SHALL be 1 iff en=1, mode=COUNT, and out is all-ones (dir=1) or all-zeros (dir=0); otherwise 0.
REQ-022 chg SHALL be 1 for exactly one cycle after any edge where out's next value differs from its current value; a LOAD of an equal value SHALL give chg=0.
REQ-023 Latency: every mode takes effect in one clock; mode and dir changes apply on the same edge with no pipeline.
REQ-024 WIDTH=1: COUNT SHALL toggle bit 0 every enabled edge in both directions; tc follows REQ-021.

Reset
REQ-025 rst=1 SHALL immediately force out=RST_VAL and chg=0, independent of clk.
REQ-026 While rst=1, out SHALL hold RST_VAL; tc SHALL follow REQ-021 using RST_VAL.
REQ-027 Reset mid-operation (any mode) SHALL abandon the pending update; the first edge after rst falls SHALL operate normally from RST_VAL.

Configuration
REQ-028 Macro TOGGLE_REG_PARITY_EN defined: add output parity (1 bit), a register updated with out's next value and equal to XOR-reduction of out; reset value is XOR of RST_VAL.
REQ-029 Macro TOGGLE_REG_PARITY_EN undefined: parity port and register SHALL not exist; all other behaviour identical.

Verification
REQ-030 WIDTH=8, rst pulse mid-cycle with out=8'h5A -> out=8'h00 and chg=0 before the next clk edge.
REQ-031 TOGGLE, out=8'h0F, t_in=8'hFF -> out=8'hF0, chg=1; next cycle t_in=8'h00 -> out=8'hF0, chg=0.
REQ-032 COUNT up from 8'hFE over 3 edges -> out 8'hFF (tc=1), 8'h00, 8'h01; tc=0 once out leaves 8'hFF.
REQ-033 COUNT down from 8'h01 over 2 edges -> out 8'h00 (tc=1), then 8'hFF.
REQ-034 LOAD load_val=8'hA5 from 8'hA5 -> out=8'hA5, chg=0; en=0 with mode=LOAD, load_val=8'h3C -> out stays 8'hA5.
REQ-035 With TOGGLE_REG_PARITY_EN, LOAD 8'h07 -> parity=1; TOGGLE t_in=8'h01 -> out=8'h06, parity=0.
